// File: rtl/reg_file_autoinit.sv
// Register file with two combinational read ports, one synchronous write port and a
// built-in sequencer that walks every register with a mode-selected value after reset/Init.

module rf_rdport #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [2**AW-1:0][DW-1:0] core,
  input  logic [AW-1:0]            addr,
  input  logic                     busy,
  input  logic                     wr_fwd,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            data
);
  always_comb begin
    data = core[addr];
    if (BYPASS && wr_fwd && (addr == wr_addr)) data = wr_data;
    // Zero register and the busy blanking override everything, including bypass.
    if ((ZERO_REG && (addr == '0)) || busy) data = '0;
  end
endmodule

module reg_file_autoinit #(
  parameter int          DW        = 8,
  parameter int          AW        = 3,
  parameter int          INIT_MODE = 1,
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter bit          ZERO_REG  = 1'b0,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Init,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [DW-1:0] WrData,
  input  logic [AW-1:0] RdAddrA,
  input  logic [AW-1:0] RdAddrB,
  output logic [DW-1:0] RdDataA,
  output logic [DW-1:0] RdDataB,
  output logic          Busy,
  output logic          Ready,
  output logic          WrErr
);
  localparam int DEPTH = 2**AW;
  localparam int NRD   = 2;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                     state, nxt_state;
  logic [AW-1:0]              ptr, nxt_ptr;
  logic [DEPTH-1:0][DW-1:0]   core;
  logic                       wr_go, drop, wr_fwd;
  logic [AW-1:0]              wr_addr;
  logic [DW-1:0]              wr_data, init_data;
  logic [DW+AW-1:0]           ptr_ext;
  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NRD-1:0][DW-1:0]     rd_data;

  // Zero-extend then truncate so any DW/AW ratio works for the index pattern.
  assign ptr_ext = {{DW{1'b0}}, ptr};

  always_comb begin
    case (INIT_MODE)
      1:       init_data = ptr_ext[DW-1:0];
      2:       init_data = INIT_VAL;
      default: init_data = '0;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    wr_go     = 1'b0;
    wr_addr   = WrAddr;
    wr_data   = WrData;
    drop      = 1'b0;
    case (state)
      S_INIT: begin
        wr_go   = 1'b1;
        wr_addr = ptr;
        wr_data = init_data;
        nxt_ptr = ptr + 1'b1;
        drop    = WrEn;
        if (ptr == '1) nxt_state = S_READY;
      end
      default: begin
        if (Init) begin
          nxt_state = S_INIT;
          nxt_ptr   = '0;
          drop      = WrEn;
        end else begin
          wr_go = WrEn;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
      ptr   <= '0;
      WrErr <= 1'b0;
    end else begin
      state <= nxt_state;
      ptr   <= nxt_ptr;
      WrErr <= drop;
    end
  end

  // Storage is deliberately unreset; the sequencer rewrites every slot.
  always_ff @(posedge Clk) begin
    if (wr_go && !(ZERO_REG && (wr_addr == '0))) core[wr_addr] <= wr_data;
  end

  assign Busy   = (state == S_INIT);
  assign Ready  = ~Busy;
  assign wr_fwd = WrEn && (state == S_READY) && !Init;

  assign rd_addr = {RdAddrB, RdAddrA};

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    rf_rdport #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd (
      .core    (core),
      .addr    (rd_addr[g]),
      .busy    (Busy),
      .wr_fwd  (wr_fwd),
      .wr_addr (WrAddr),
      .wr_data (WrData),
      .data    (rd_data[g])
    );
  end

  assign RdDataA = rd_data[0];
  assign RdDataB = rd_data[1];
endmodule

// File: tb/tb_reg_file_autoinit.sv
// Bench for reg_file_autoinit: default instance plus a zero-reg / constant-init instance
// sharing stimulus, checked against a counter-and-array reference model.

module tb_reg_file_autoinit;
  logic       Clk, Reset, Init, WrEn;
  logic [2:0] WrAddr, RdAddrA, RdAddrB;
  logic [7:0] WrData, RdDataA, RdDataB, zRdDataA, zRdDataB;
  logic       Busy, Ready, WrErr, zBusy, zReady, zWrErr;

  reg_file_autoinit dut (
    .Clk(Clk), .Reset(Reset), .Init(Init), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(RdDataA), .RdDataB(RdDataB),
    .Busy(Busy), .Ready(Ready), .WrErr(WrErr));

  reg_file_autoinit #(.INIT_MODE(2), .INIT_VAL(8'h3C), .ZERO_REG(1'b1)) dut_z (
    .Clk(Clk), .Reset(Reset), .Init(Init), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(zRdDataA), .RdDataB(zRdDataB),
    .Busy(zBusy), .Ready(zReady), .WrErr(zWrErr));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nvec = 0, nfail = 0;

  // Reference model: remaining init steps, pending error flag, register contents.
  int         cnt;
  logic       err;
  logic [7:0] mem[8], memz[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input bit z, input logic [2:0] a);
    if (cnt > 0) return 8'h00;
    if (z && a == 3'd0) return 8'h00;
    if (WrEn && !Init && a == WrAddr) return WrData;
    return z ? memz[a] : mem[a];
  endfunction

  task automatic model_step();
    int idx;
    if (cnt > 0) begin
      idx = 8 - cnt;
      mem[idx]  = 8'(idx);
      memz[idx] = (idx == 0) ? 8'h00 : 8'h3C;
      cnt--;
      err = WrEn;
    end else if (Init) begin
      cnt = 8;
      err = WrEn;
    end else begin
      err = 1'b0;
      if (WrEn) begin
        mem[WrAddr] = WrData;
        if (WrAddr != 3'd0) memz[WrAddr] = WrData;
      end
    end
  endtask

  task automatic drive(input logic i, we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra, rb);
    Init = i; WrEn = we; WrAddr = wa; WrData = wd; RdAddrA = ra; RdAddrB = rb;
    #1;
    chk("busy",    8'(Busy),   8'(cnt > 0));
    chk("ready",   8'(Ready),  8'(cnt == 0));
    chk("wrerr",   8'(WrErr),  8'(err));
    chk("rda",     RdDataA,    exp_rd(0, ra));
    chk("rdb",     RdDataB,    exp_rd(0, rb));
    chk("z_busy",  8'(zBusy),  8'(cnt > 0));
    chk("z_wrerr", 8'(zWrErr), 8'(err));
    chk("z_rda",   zRdDataA,   exp_rd(1, ra));
    chk("z_rdb",   zRdDataB,   exp_rd(1, rb));
  endtask

  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic apply(input logic i, we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra, rb);
    drive(i, we, wa, wd, ra, rb);
    step();
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    WrEn = 0; Init = 0;
    Reset = 1'b1;
    #1;
    cnt = 8; err = 1'b0;
    chk("rst_busy",  8'(Busy),  8'd1);
    chk("rst_ready", 8'(Ready), 8'd0);
    chk("rst_wrerr", 8'(WrErr), 8'd0);
    repeat (n) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Counts edges until Busy falls; bounded so a stuck sequencer still reaches the summary.
  task automatic busy_len(input string name, input int exp);
    int n = 0;
    while (Busy && n < 20) begin
      idle();
      n++;
    end
    chk(name, 8'(n), 8'(exp));
  endtask

  typedef struct {
    logic       i, we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra, rb;
    logic [7:0] ea, eb;
    logic       eerr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 0, 0, 8'h00, 0, 7, 8'h00, 8'h07, 0};
    tbl[1]  = '{0, 0, 0, 8'h00, 1, 6, 8'h01, 8'h06, 0};
    tbl[2]  = '{0, 0, 0, 8'h00, 2, 5, 8'h02, 8'h05, 0};
    tbl[3]  = '{0, 0, 0, 8'h00, 3, 4, 8'h03, 8'h04, 0};
    tbl[4]  = '{0, 1, 5, 8'hA5, 5, 4, 8'hA5, 8'h04, 0};
    tbl[5]  = '{0, 0, 0, 8'h00, 5, 5, 8'hA5, 8'hA5, 0};
    tbl[6]  = '{0, 1, 7, 8'h3E, 7, 7, 8'h3E, 8'h3E, 0};
    tbl[7]  = '{0, 1, 1, 8'h99, 7, 1, 8'h3E, 8'h99, 0};
    tbl[8]  = '{0, 0, 0, 8'h00, 1, 0, 8'h99, 8'h00, 0};
    tbl[9]  = '{0, 1, 0, 8'h42, 0, 6, 8'h42, 8'h06, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 8'h42, 8'h42, 0};

    Init = 0; WrEn = 0; WrAddr = 0; WrData = 0; RdAddrA = 0; RdAddrB = 0;
    cnt = 8; err = 0;
    for (int k = 0; k < 8; k++) begin mem[k] = 0; memz[k] = 0; end
    @(negedge Clk);

    // Power-up init, then directed reads/writes including bypass.
    do_reset(2);
    busy_len("init_len", 8);
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].i, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].ra, tbl[k].rb);
      chk($sformatf("tbl%0d_a", k),   RdDataA,   tbl[k].ea);
      chk($sformatf("tbl%0d_b", k),   RdDataB,   tbl[k].eb);
      chk($sformatf("tbl%0d_err", k), 8'(WrErr), 8'(tbl[k].eerr));
      step();
    end

    // Write during INIT slot 3 is dropped and flagged for one cycle.
    do_reset(2);
    idle(); idle(); idle();
    apply(0, 1, 3, 8'hFF, 0, 0);
    chk("init_wr_err", 8'(WrErr), 8'd1);
    idle();
    chk("init_wr_err_clr", 8'(WrErr), 8'd0);
    busy_len("init_len2", 3);
    drive(0, 0, 0, 0, 3, 3);
    chk("init_wr_drop", RdDataA, 8'h03);

    // Reset mid-INIT restarts the full walk.
    do_reset(1);
    idle(); idle(); idle();
    do_reset(1);
    busy_len("restart_len", 8);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 3'(k), 3'(7 - k));
      chk("restart_rd", RdDataA, 8'(k));
    end

    // Init beats a simultaneous write.
    apply(0, 1, 2, 8'h77, 0, 0);
    apply(1, 1, 2, 8'h55, 2, 2);
    chk("reinit_err",  8'(WrErr), 8'd1);
    chk("reinit_busy", 8'(Busy),  8'd1);
    busy_len("reinit_len", 8);
    drive(0, 0, 0, 0, 2, 2);
    chk("reinit_rd2", RdDataA, 8'h02);

    // Zero-register instance with constant init.
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 3'(k), 3'(k));
      chk("z_init_rd", zRdDataA, (k == 0) ? 8'h00 : 8'h3C);
    end
    apply(0, 1, 0, 8'h77, 0, 0);
    chk("z_wr0_noerr", 8'(zWrErr), 8'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("z_wr0_rd", zRdDataA, 8'h00);
    chk("wr0_rd",   RdDataA,  8'h77);
    step();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 3));
      else apply($urandom_range(0, 24) == 0, 1'($urandom), 3'($urandom), 8'($urandom),
                 3'($urandom), 3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
